serial_chunk_adder: RTL and testbench

Multi-cycle, area-reduced n-bit adder that processes K bits per clock with a registered ripple carry between chunks. It generalises the datapath's combinational n-bit adder with carry-in, carry-out, signed overflow, and a start/busy/done handshake. It sits beside the ALU for wide operands where a full-width ripple adder would break timing.

---
 rtl/serial_chunk_adder.sv | 151 +++++++++++++++
 tb/tb_serial_chunk_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: N-bit adder that adds K bits per clock through a
// registered ripple carry, with a start/busy/done handshake.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_chunk_adder #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         i_sub,
`endif
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_s,
  output logic         o_cout,
  output logic         o_ovf
);

  localparam int unsigned CHUNKS = N / K;
  localparam int unsigned CNT_W  = $clog2(CHUNKS + 1);
  localparam int unsigned SUM_W  = K + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;

  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_psum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_am;
  logic               r_bm;
  logic               r_busy;
  logic               r_done;
  logic [N-1:0]       r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [N-1:0]       w_b_in;
  logic               w_c_in;
  logic [SUM_W-1:0]   w_chunk_sum;
  logic [N-1:0]       w_psum_next;

  // Operand B / carry-in as seen by the datapath (inverted B and forced carry when subtracting)
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in = i_sub ? ~i_b : i_b;
  assign w_c_in = i_sub ? 1'b1 : i_cin;
`else
  assign w_b_in = i_b;
  assign w_c_in = i_cin;
`endif

  // One K-bit chunk addition and the partial sum with the new chunk shifted in at the top
  always_comb begin
    w_chunk_sum = SUM_W'(r_a[K-1:0]) + SUM_W'(r_b[K-1:0]) + SUM_W'(r_carry);
    w_psum_next = N'({w_chunk_sum[K-1:0], r_psum} >> K);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic and accept/last-chunk strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(CHUNKS - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, chunk shifting, carry ripple and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_am    <= 1'b0;
      r_bm    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_next == S_BUSY);
      r_done <= (w_next == S_DONE);
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= w_b_in;
        r_carry <= w_c_in;
        r_am    <= i_a[N-1];
        r_bm    <= w_b_in[N-1];
        r_cnt   <= '0;
        r_psum  <= '0;
      end else if (r_state == S_BUSY) begin
        r_a     <= r_a >> K;
        r_b     <= r_b >> K;
        r_carry <= w_chunk_sum[K];
        r_cnt   <= r_cnt + CNT_W'(1);
        r_psum  <= w_psum_next;
        if (w_last) begin
          r_s    <= w_psum_next;
          r_cout <= w_chunk_sum[K];
          r_ovf  <= (r_am == r_bm) && (w_psum_next[N-1] != r_am);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder (N=8, K=2). A cycle-level
// behavioural model predicts every output; directed ops pin known results.
// Subtract cases are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_chunk_adder;

  localparam int unsigned N  = 8;
  localparam int unsigned K  = 2;
  localparam int unsigned CH = N / K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout, ovf;
  logic [N-1:0] s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.N(N), .K(K)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (sub),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_s     (s),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  // Arithmetic reference for one operation
  function automatic void calc(input logic [N-1:0] fa, input logic [N-1:0] fb,
                               input logic fcin, input logic fsub,
                               output logic [N-1:0] fs, output logic fco, output logic fov);
    logic [N-1:0] bb;
    int c, u, v;
    bb  = fsub ? ~fb : fb;
    c   = fsub ? 1 : int'(fcin);
    u   = int'(fa) + int'(bb) + c;
    v   = int'($signed(fa)) + int'($signed(bb)) + c;
    fs  = N'(u);
    fco = (u >= (1 << N));
    fov = (v > (1 << (N - 1)) - 1) || (v < -(1 << (N - 1)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining-cycle count plus pending result
  logic         m_valid = 1'b0;
  logic         m_busy, m_done, m_cout, m_ovf;
  logic [N-1:0] m_s;
  int           m_rem;
  logic [N-1:0] p_s;
  logic         p_co, p_ov;
  logic         eff_sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign eff_sub = sub;
`else
  assign eff_sub = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_rem = 0;
    end else if (m_valid) begin
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_s = p_s; m_cout = p_co; m_ovf = p_ov;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          calc(a, b, cin, eff_sub, p_s, p_co, p_ov);
          m_rem  = CH;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Compare process: every output, every cycle after the first reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("s",    32'(s),    32'(m_s));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("ovf",  32'(ovf),  32'(m_ovf));
      chk("busy_and_done", 32'(busy & done), 32'(0));
    end
  end

  // Issue a one-cycle start; returns at the negedge of busy cycle 1
  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tcin, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cyc = negedges waited
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  task automatic op_check(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [N-1:0] es, input logic eco, input logic eov);
    int cyc;
    start_op(ta, tb, tcin, tsub);
    wait_done(cyc);
    chk({name, "_s"},    32'(s),    32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(eco));
    chk({name, "_ovf"},  32'(ovf),  32'(eov));
  endtask

  initial begin
    int cyc;
    logic [N-1:0] rs;
    logic rco, rov;

    // Reset held for two cycles with start asserted
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_s",    32'(s),    32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf",  32'(ovf),  32'(0));
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'(0));

    // Basic op with latency measurement
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    chk("busy_c1", 32'(busy), 32'(1));
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'(CH));
    chk("add_s",    32'(s),    32'(8'h4B));
    chk("add_cout", 32'(cout), 32'(0));
    chk("add_ovf",  32'(ovf),  32'(0));

    op_check("carry", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op_check("cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

    // Start pulsed during busy is ignored
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ignore_s", 32'(s), 32'(8'h4B));
    @(negedge clk);
    chk("ignore_idle", 32'(busy), 32'(0));

    // Start held through DONE gives back-to-back ops
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    wait_done(cyc);
    chk("b2b_first_s", 32'(s), 32'(8'h46));
    a = 8'h80; b = 8'h80; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart_busy", 32'(busy), 32'(1));
    wait_done(cyc);
    chk("b2b_period", 32'(cyc + 1), 32'(CH + 1));
    chk("b2b_second_s",    32'(s),    32'(8'h00));
    chk("b2b_second_cout", 32'(cout), 32'(1));
    chk("b2b_second_ovf",  32'(ovf),  32'(1));

    // Reset in busy cycle 3 aborts
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_s",    32'(s),    32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end

`ifdef SERIAL_ADDER_SUB_EN
    op_check("sub1", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op_check("sub2", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    // Randomized ops, occasional spurious start during busy and idle gaps
    for (int n = 0; n < 60; n++) begin
      logic [N-1:0] ra, rb;
      logic rc, rsb;
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rsb = 1'($urandom);
`else
      rsb = 1'b0;
`endif
      calc(ra, rb, rc, rsb, rs, rco, rov);
      start_op(ra, rb, rc, rsb);
      if ($urandom_range(0, 3) == 0) begin
        a = N'($urandom); b = N'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(cyc);
      chk("rand_s",    32'(s),    32'(rs));
      chk("rand_cout", 32'(cout), 32'(rco));
      chk("rand_ovf",  32'(ovf),  32'(rov));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
